// File: rtl/servant_uart_pkg.sv
// Shared types and register map for the servant Wishbone UART transmitter.
package servant_uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  // STATUS read-back bit positions
  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;
  localparam int unsigned ST_IRQEN = 4;

  // STATUS write: bit that loads irq_enable
  localparam int unsigned CTL_IRQEN = 1;

endpackage

// File: rtl/servant_uart_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit so full/empty
// fall out of a pointer compare.
module servant_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_c = (wr_ptr == rd_ptr);
  assign rdata_c = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/servant_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter with TX FIFO for the servant data bus.
// Optional TX-done interrupt enabled by defining SERVANT_UART_IRQ_EN.
module servant_uart_tx
  import servant_uart_pkg::*;
#(
  parameter int unsigned DIVISOR    = 139,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              i_wb_adr,
  input  logic [DATA_W-1:0] i_wb_dat,
  input  logic              i_wb_we,
  input  logic              i_wb_cyc,
  output logic [DATA_W-1:0] o_wb_rdt,
  output logic              o_wb_ack,
  output logic              o_q,
  output logic              o_irq
);

  localparam int unsigned CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  uart_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              overflow;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  logic              wb_act_c;
  logic              wr_data_c;
  logic              wr_stat_c;
  logic              bit_done_c;
  logic              pop_c;
  logic              irq_en_c;
  logic [DATA_W-1:0] status_c;

  // Side effects only happen while the ack is being presented
  assign wb_act_c   = i_wb_cyc & o_wb_ack;
  assign wr_data_c  = wb_act_c & i_wb_we & (i_wb_adr == ADR_DATA);
  assign wr_stat_c  = wb_act_c & i_wb_we & (i_wb_adr == ADR_STATUS);
  assign bit_done_c = (cnt == CNT_LAST);
  assign pop_c      = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done_c));

  servant_uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk),
    .rst_n   (wb_rst_n),
    .push    (wr_data_c),
    .wdata   (i_wb_dat),
    .pop     (pop_c),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  always_comb begin
    status_c           = '0;
    status_c[ST_BUSY]  = (state != IDLE);
    status_c[ST_FULL]  = fifo_full;
    status_c[ST_EMPTY] = fifo_empty;
    status_c[ST_OVF]   = overflow;
    status_c[ST_IRQEN] = irq_en_c;
  end

  // Bus handshake, read data and sticky overflow
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      overflow <= 1'b0;
    end else begin
      o_wb_ack <= i_wb_cyc & ~o_wb_ack;
      if (i_wb_cyc & ~o_wb_ack & ~i_wb_we & (i_wb_adr == ADR_STATUS))
        o_wb_rdt <= status_c;
      else
        o_wb_rdt <= '0;
      if (wr_stat_c)
        overflow <= 1'b0;
      else if (wr_data_c & fifo_full)
        overflow <= 1'b1;
    end
  end

  // Baud-rate serialiser; o_q is loaded with the level of the state being entered
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      o_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shift <= fifo_rdata;
            cnt   <= '0;
            o_q   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_done_c) begin
            cnt     <= '0;
            bit_idx <= '0;
            o_q     <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done_c) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_q   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              o_q     <= shift[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done_c) begin
            cnt <= '0;
            if (!fifo_empty) begin
              shift <= fifo_rdata;
              o_q   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          o_q   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERVANT_UART_IRQ_EN
  logic irq_en;
  logic irq_en_nxt_c;
  logic going_idle_c;

  assign irq_en_c     = irq_en;
  assign irq_en_nxt_c = wr_stat_c ? i_wb_dat[CTL_IRQEN] : irq_en;
  assign going_idle_c = (state == IDLE) | ((state == STOP) & bit_done_c);

  // Interrupt tracks the post-edge view so it drops right after a push
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irq_en <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      irq_en <= irq_en_nxt_c;
      o_irq  <= irq_en_nxt_c & ~wr_data_c & fifo_empty & going_idle_c;
    end
  end
`else
  assign irq_en_c = 1'b0;
  assign o_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_servant_uart_tx.sv
// Scoreboard bench for servant_uart_tx: bytes queued on write, frames decoded from o_q.
module tb_servant_uart_tx;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int          FRAME = 10 * DIV;

  logic       wb_clk   = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       i_wb_adr = 1'b0;
  logic [7:0] i_wb_dat = 8'h00;
  logic       i_wb_we  = 1'b0;
  logic       i_wb_cyc = 1'b0;
  logic [7:0] o_wb_rdt;
  logic       o_wb_ack;
  logic       o_q;
  logic       o_irq;

  servant_uart_tx #(
    .DIVISOR    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_q      (o_q),
    .o_irq    (o_irq)
  );

  always #5 wb_clk = ~wb_clk;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  always @(posedge wb_clk) cyc_cnt++;

  // Scoreboard and serial-line monitor
  logic [7:0] sb[$];
  bit         in_frame = 0;
  bit         ferr = 0;
  int         idx = 0;
  logic [7:0] cur = 8'h00;
  int         frame_start = 0;
  int         prev_start = 0;

  always @(negedge wb_clk) begin
    if (!wb_rst_n) begin
      in_frame = 0;
      sb.delete();
    end else begin
      if (!in_frame && o_q === 1'b0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: o_q=0 at cycle %0d, required idle 1", cyc_cnt);
        end else begin
          cur = sb.pop_front();
          in_frame = 1;
          idx = 0;
          ferr = 0;
          prev_start = frame_start;
          frame_start = cyc_cnt;
        end
      end
      if (in_frame) begin
        int  slot;
        logic exp_bit;
        slot = idx / DIV;
        if (slot == 0)      exp_bit = 1'b0;
        else if (slot == 9) exp_bit = 1'b1;
        else                exp_bit = cur[slot-1];
        if (o_q !== exp_bit) ferr = 1;
        if (idx == FRAME - 1) begin
          tests++;
          if (ferr) begin
            fails++;
            $display("FAIL frame_0x%02h: serial waveform differs from required 8N1 frame", cur);
          end
          in_frame = 0;
        end
        idx++;
      end
    end
  end

  task automatic bus_write(input logic adr, input logic [7:0] dat, output int ack_at);
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = adr; i_wb_dat = dat;
    ack_at = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk);
      if (o_wb_ack === 1'b1) begin ack_at = cyc_cnt; break; end
    end
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    tests++;
    if (ack_at < 0) begin
      fails++;
      $display("FAIL write_ack: no ack within 4 cycles, required 1");
    end
  endtask

  task automatic bus_read(input logic adr, output logic [7:0] rdt);
    int got;
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = adr;
    got = 0; rdt = 8'hxx;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk);
      if (o_wb_ack === 1'b1) begin got = 1; rdt = o_wb_rdt; break; end
    end
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b0;
    tests++;
    if (got == 0) begin
      fails++;
      $display("FAIL read_ack: no ack within 4 cycles, required 1");
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wb_clk);
      if (sb.size() == 0 && !in_frame) begin done = 1; break; end
    end
    repeat (3) @(negedge wb_clk);
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: %0d bytes pending after %0d cycles, required 0", sb.size(), budget);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    repeat (3) @(negedge wb_clk);
    tests++;
    if ({o_q, o_wb_ack, o_wb_rdt, o_irq} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: q=%b ack=%b rdt=%h irq=%b, required 1 0 00 0",
               o_q, o_wb_ack, o_wb_rdt, o_irq);
    end
    #1 wb_rst_n = 1'b1;
    bus_read(1'b1, rd);
    tests++;
    if (rd !== 8'h04) begin fails++; $display("FAIL reset_status: got %h, required 04", rd); end
    bus_read(1'b0, rd);
    tests++;
    if (rd !== 8'h00) begin fails++; $display("FAIL read_data_reg: got %h, required 00", rd); end
  endtask

  task automatic test_single_byte();
    int a;
    logic [7:0] rd;
    sb.push_back(8'h55);
    bus_write(1'b0, 8'h55, a);
    bus_read(1'b1, rd);
    tests++;
    if (rd !== 8'h05) begin fails++; $display("FAIL busy_status: got %h, required 05", rd); end
    wait_idle(200);
    tests++;
    if (frame_start - a !== 2) begin
      fails++;
      $display("FAIL start_latency: got %0d cycles after ack, required 2", frame_start - a);
    end
    bus_read(1'b1, rd);
    tests++;
    if (rd !== 8'h04) begin fails++; $display("FAIL idle_status: got %h, required 04", rd); end
  endtask

  task automatic test_back_to_back();
    int a;
    sb.push_back(8'h41);
    sb.push_back(8'h42);
    bus_write(1'b0, 8'h41, a);
    bus_write(1'b0, 8'h42, a);
    wait_idle(300);
    tests++;
    if (frame_start - prev_start !== FRAME) begin
      fails++;
      $display("FAIL frame_gap: starts %0d apart, required %0d", frame_start - prev_start, FRAME);
    end
  endtask

  task automatic test_overflow();
    int a;
    logic [7:0] rd;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(8'(8'h10 + i));
      bus_write(1'b0, 8'(8'h10 + i), a);
    end
    bus_read(1'b1, rd);
    tests++;
    if (rd !== 8'h0B) begin fails++; $display("FAIL overflow_status: got %h, required 0B", rd); end
    bus_write(1'b1, 8'h00, a);
    bus_read(1'b1, rd);
    tests++;
    if ((rd & 8'h09) !== 8'h01) begin
      fails++;
      $display("FAIL overflow_clear: busy/ovf bits %h, required 01", rd & 8'h09);
    end
    wait_idle(1000);
  endtask

  task automatic test_ack_hold();
    logic [4:0] acks;
    sb.push_back(8'h33);
    sb.push_back(8'h33);
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = 1'b0; i_wb_dat = 8'h33;
    for (int k = 0; k < 5; k++) begin
      @(negedge wb_clk);
      acks[k] = o_wb_ack;
    end
    @(posedge wb_clk); #1;
    i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    tests++;
    if (acks !== 5'b01010) begin
      fails++;
      $display("FAIL ack_pattern: got %b (cycle1=lsb), required 01010", acks);
    end
    wait_idle(300);
  endtask

  task automatic test_reset_midframe();
    int a;
    int lows;
    logic [7:0] rd;
    sb.push_back(8'hA5);
    bus_write(1'b0, 8'hA5, a);
    repeat (11) @(negedge wb_clk);
    tests++;
    if (o_q !== 1'b0) begin fails++; $display("FAIL midframe_bit1: q=%b, required 0", o_q); end
    #1 wb_rst_n = 1'b0;
    #1;
    tests++;
    if (o_q !== 1'b1) begin fails++; $display("FAIL async_reset_q: q=%b, required 1", o_q); end
    repeat (3) @(negedge wb_clk);
    #1 wb_rst_n = 1'b1;
    bus_read(1'b1, rd);
    tests++;
    if (rd !== 8'h04) begin fails++; $display("FAIL post_reset_status: got %h, required 04", rd); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge wb_clk);
      if (o_q !== 1'b1) lows++;
    end
    tests++;
    if (lows != 0) begin fails++; $display("FAIL no_resume: %0d low cycles, required 0", lows); end
  endtask

  task automatic test_irq();
    int a;
    logic [7:0] rd;
`ifdef SERVANT_UART_IRQ_EN
    int rise;
    bus_write(1'b1, 8'h02, a);
    @(negedge wb_clk);
    tests++;
    if (o_irq !== 1'b1) begin fails++; $display("FAIL irq_enable_idle: irq=%b, required 1", o_irq); end
    bus_read(1'b1, rd);
    tests++;
    if (rd !== 8'h14) begin fails++; $display("FAIL irqen_status: got %h, required 14", rd); end
    sb.push_back(8'h00);
    bus_write(1'b0, 8'h00, a);
    @(negedge wb_clk);
    tests++;
    if (o_irq !== 1'b0) begin fails++; $display("FAIL irq_drop: irq=%b after push, required 0", o_irq); end
    rise = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge wb_clk);
      if (o_irq === 1'b1) begin rise = cyc_cnt; break; end
    end
    tests++;
    if (rise != frame_start + FRAME) begin
      fails++;
      $display("FAIL irq_rise: cycle %0d, required %0d", rise, frame_start + FRAME);
    end
    bus_write(1'b1, 8'h00, a);
    @(negedge wb_clk);
    tests++;
    if (o_irq !== 1'b0) begin fails++; $display("FAIL irq_disable: irq=%b, required 0", o_irq); end
`else
    bus_write(1'b1, 8'h02, a);
    bus_read(1'b1, rd);
    tests++;
    if (rd !== 8'h04) begin fails++; $display("FAIL irqen_absent: got %h, required 04", rd); end
    tests++;
    if (o_irq !== 1'b0) begin fails++; $display("FAIL irq_tied: irq=%b, required 0", o_irq); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_ack_hold();
    test_reset_midframe();
    test_irq();
    wait_idle(200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/servant_uart_tx.md
Name: servant_uart_tx

Overview:
- Wishbone-slave UART transmitter on the servant data bus, on a spare mux slot.
- Replaces bit-banging through the 1-bit GPIO.
- Firmware writes bytes into a small TX FIFO; a baud-rate state machine serialises them 8N1, LSB first, onto o_q, which drives the board TX pin downstream of the mux.

Parameters:
- DIVISOR, 139, wb_clk cycles per bit (16 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..256.

Ports:
- wb_clk  in  1  system clock
- wb_rst_n  in  1  asynchronous active-low reset
- i_wb_adr  in  1  word select: 0 = DATA, 1 = STATUS
- i_wb_dat  in  8  write data
- i_wb_we  in  1  write enable
- i_wb_cyc  in  1  cycle valid
- o_wb_rdt  out  8  read data
- o_wb_ack  out  1  single-cycle acknowledge
- o_q  out  1  serial TX line, idle high
- o_irq  out  1  TX-done interrupt (Optional Feature)

Behaviour:
- Reset (wb_rst_n low, asynchronous):
  - Outputs: o_q=1, o_wb_ack=0, o_wb_rdt=0, o_irq=0.
  - Internal: FIFO emptied, overflow flag cleared, FSM in IDLE, baud counter 0.
  - Reset mid-frame truncates the frame immediately; the line returns high. No byte is resumed.
- Bus handshake:
  - o_wb_ack <= i_wb_cyc & ~o_wb_ack: one ack cycle after cyc rises, never two consecutive.
  - Side effects occur only in the ack cycle.
  - o_wb_rdt is registered and valid in the ack cycle; 0 otherwise.
- Write DATA:
  - Pushes i_wb_dat if the FIFO is not full.
  - If full, the byte is dropped and sticky overflow is set.
  - "Full" uses the pre-cycle state, so a same-cycle pop does not make room.
- Write STATUS: any value clears overflow; bit1 = irq_enable (Optional Feature; ignored otherwise).
- Read DATA returns 0.
- Read STATUS fields:
  - bit0 busy (FSM != IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow
  - bit4 irq_enable (0 if feature absent)
  - bits7:5 = 0
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty (registered), pop the head into the shift register and go to START. o_q=0 from the next cycle.
  - START: o_q=0 for DIVISOR cycles, then DATA with bit index 0.
  - DATA: o_q=shift[0] for DIVISOR cycles per bit, shifting right. After bit 7 go to STOP.
  - STOP: o_q=1 for DIVISOR cycles. Then pop and go to START if FIFO non-empty (no idle gap between bytes), else IDLE.
- Baud counter:
  - Counts 0..DIVISOR-1; the bit boundary is at DIVISOR-1.
  - Reloads to 0 on every state entry.
  - Width is $clog2(DIVISOR).
- Frame length: exactly 10*DIVISOR cycles.
- FIFO:
  - Read/write pointers with one extra wrap bit; full/empty derived from pointer compare.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle are both honoured when neither boundary blocks them.
- A push to an empty FIFO is not popped in the same cycle; transmission starts one cycle later.

Optional Feature:
- Macro SERVANT_UART_IRQ_EN.
- Defined:
  - o_irq is registered: irq_enable & empty & FSM==IDLE.
  - It rises the cycle after the last stop bit completes and clears when a byte is pushed or irq_enable is cleared.
- Undefined:
  - o_irq is tied 0.
  - irq_enable storage is removed; STATUS bit4 reads 0.
  - The port list is unchanged.

Decomposition:
- Package servant_uart_pkg holds:
  - FSM state typedef (IDLE/START/DATA/STOP).
  - Register offsets ADR_DATA=0, ADR_STATUS=1.
  - Status bit positions ST_BUSY, ST_FULL, ST_EMPTY, ST_OVF, ST_IRQEN.
- One sub-module, servant_uart_fifo: synchronous FIFO parameterised by width=8 and FIFO_DEPTH, exposing push/pop/full/empty. The top holds the bus, FSM and baud logic.

Test Plan:
- DIVISOR=4, write 0x55 to DATA -> after ack+2 cycles o_q: 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles); busy=1 throughout, STATUS reads 0x04 afterwards.
- Write 0x41, 0x42 back-to-back -> frames contiguous: stop bit of 0x41 is followed immediately by the start bit of 0x42, total 80 cycles with no idle gap.
- FIFO_DEPTH=8, DIVISOR=1000, write 10 bytes quickly -> first byte popped, 8 queued, 10th dropped; STATUS reads 0x0B (busy|full|ovf); write STATUS -> overflow bit clears.
- Assert wb_rst_n low mid data bit of byte 0xA5 -> o_q=1 asynchronously, STATUS=0x04, no further frame after release.
- Hold i_wb_cyc high for 5 cycles writing 0x33 -> o_wb_ack pulses on cycles 2 and 4 only, two pushes of 0x33 occur.
- SERVANT_UART_IRQ_EN defined, write STATUS=0x02, then DATA=0x00 -> o_irq drops the cycle after the push and rises exactly 1 cycle after the stop bit's last cycle.
